// File: rtl/sudoku_grid_tx_sequencer_pkg.sv
// Shared state encoding and ASCII constants for the sudoku grid transmitter.
// Imported by the encoder, the sequencer top and anything that decodes its bytes.
package sudoku_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT,
        CR,
        LF,
        DONE
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_BAD  = 8'h3F;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [3:0] GRID_MAX   = 4'd8;

endpackage

// File: rtl/sudoku_grid_tx_sequencer_if.sv
// Bundle of grid-store, UART and control signals around the grid sequencer.
// The master side is the sequencer; the slave side is the grid store, UART and controller.
interface sudoku_grid_tx_sequencer_if;

    logic       i_Start;
    logic [3:0] o_Cell_X;
    logic [3:0] o_Cell_Y;
    logic [8:0] i_Cell;
    logic [7:0] o_Tx_Byte;
    logic       o_Tx_Ready;
    logic       i_Tx_Completed;
    logic       o_Busy;
    logic       o_Done;
    logic       o_Bad_Cell;

    modport master (
        input  i_Start,
        input  i_Cell,
        input  i_Tx_Completed,
        output o_Cell_X,
        output o_Cell_Y,
        output o_Tx_Byte,
        output o_Tx_Ready,
        output o_Busy,
        output o_Done,
        output o_Bad_Cell
    );

    modport slave (
        output i_Start,
        output i_Cell,
        output i_Tx_Completed,
        input  o_Cell_X,
        input  o_Cell_Y,
        input  o_Tx_Byte,
        input  o_Tx_Ready,
        input  o_Busy,
        input  o_Done,
        input  o_Bad_Cell
    );

endinterface

// File: rtl/sudoku_grid_tx_sequencer_encoder.sv
// Combinational one-hot cell to ASCII digit converter.
// Empty cell prints '0', a single set bit k prints '1'+k, anything else prints '?'.
module sudoku_cell_ascii_encoder
    import sudoku_pkg::*;
(
    input  logic [8:0] i_Cell,
    output logic [7:0] o_Ascii,
    output logic       o_Bad
);

    always_comb begin
        o_Ascii = ASCII_BAD;
        o_Bad   = 1'b1;
        if (i_Cell == 9'd0) begin
            o_Ascii = ASCII_ZERO;
            o_Bad   = 1'b0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                if (i_Cell == 9'(1 << k)) begin
                    o_Ascii = ASCII_ONE + 8'(k);
                    o_Bad   = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sudoku_grid_tx_sequencer.sv
// Walks a 9x9 grid row-major, encodes each cell as ASCII and hands bytes to a UART
// one at a time, optionally terminating every row with CR LF.
module sudoku_grid_tx_sequencer
    import sudoku_pkg::*;
#(
    parameter int p_ROW_TERM = 1
) (
    input logic i_Clk,
    input logic i_Rst_n,
    sudoku_grid_tx_sequencer_if.master bus
);

    localparam bit c_ROW_TERM = (p_ROW_TERM != 0);

    state_t     r_State;
    logic [3:0] r_Cell_X;
    logic [3:0] r_Cell_Y;
    logic [7:0] r_Tx_Byte;
    logic       r_Tx_Ready;
    logic       r_Busy;
    logic       r_Done;
    logic       r_Bad_Cell;

    logic [7:0] w_Ascii;
    logic       w_Bad;

    sudoku_cell_ascii_encoder u_Encoder (
        .i_Cell  (bus.i_Cell),
        .o_Ascii (w_Ascii),
        .o_Bad   (w_Bad)
    );

    // CR/LF launch their byte on the edge that enters the state and then wait in it,
    // so a new pulse is only ever issued on the edge that retires the previous byte.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State    <= IDLE;
            r_Cell_X   <= 4'd0;
            r_Cell_Y   <= 4'd0;
            r_Tx_Byte  <= 8'd0;
            r_Tx_Ready <= 1'b0;
            r_Busy     <= 1'b0;
            r_Done     <= 1'b0;
            r_Bad_Cell <= 1'b0;
        end else begin
            r_Tx_Ready <= 1'b0;
            r_Done     <= 1'b0;
            unique case (r_State)
                IDLE: begin
                    if (bus.i_Start) begin
                        r_Cell_X   <= 4'd0;
                        r_Cell_Y   <= 4'd0;
                        r_Bad_Cell <= 1'b0;
                        r_Busy     <= 1'b1;
                        r_State    <= FETCH;
                    end
                end
                FETCH: begin
                    r_State <= SEND;
                end
                SEND: begin
                    r_Tx_Byte  <= w_Ascii;
                    r_Tx_Ready <= 1'b1;
                    if (w_Bad) begin
                        r_Bad_Cell <= 1'b1;
                    end
                    r_State <= WAIT;
                end
                WAIT: begin
                    if (bus.i_Tx_Completed) begin
                        if (r_Cell_X < GRID_MAX) begin
                            r_Cell_X <= r_Cell_X + 4'd1;
                            r_State  <= FETCH;
                        end else begin
                            r_Cell_X <= 4'd0;
                            if (c_ROW_TERM) begin
                                r_Tx_Byte  <= ASCII_CR;
                                r_Tx_Ready <= 1'b1;
                                r_State    <= CR;
                            end else if (r_Cell_Y < GRID_MAX) begin
                                r_Cell_Y <= r_Cell_Y + 4'd1;
                                r_State  <= FETCH;
                            end else begin
                                r_Busy  <= 1'b0;
                                r_Done  <= 1'b1;
                                r_State <= DONE;
                            end
                        end
                    end
                end
                CR: begin
                    if (bus.i_Tx_Completed) begin
                        r_Tx_Byte  <= ASCII_LF;
                        r_Tx_Ready <= 1'b1;
                        r_State    <= LF;
                    end
                end
                LF: begin
                    if (bus.i_Tx_Completed) begin
                        if (r_Cell_Y < GRID_MAX) begin
                            r_Cell_Y <= r_Cell_Y + 4'd1;
                            r_State  <= FETCH;
                        end else begin
                            r_Busy  <= 1'b0;
                            r_Done  <= 1'b1;
                            r_State <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_State <= IDLE;
                end
                default: begin
                    r_State <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_Cell_X   = r_Cell_X;
    assign bus.o_Cell_Y   = r_Cell_Y;
    assign bus.o_Tx_Byte  = r_Tx_Byte;
    assign bus.o_Tx_Ready = r_Tx_Ready;
    assign bus.o_Busy     = r_Busy;
    assign bus.o_Done     = r_Done;
    assign bus.o_Bad_Cell = r_Bad_Cell;

endmodule
